// File: rtl/fifo_param_pkg.sv
// Shared constants and helpers for fifo_param: default sizes, clog2 and
// the parameter legality predicate evaluated at elaboration.
package fifo_param_pkg;

   localparam int FIFO_WIDTH_DEF = 8;
   localparam int FIFO_DEPTH_DEF = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Depth must be a power of two >= 4 and thresholds strictly ordered inside it.
   function automatic bit fifo_cfg_ok(input int width, input int depth,
                                      input int ae_level, input int af_level);
      return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             (ae_level >= 1) && (ae_level < af_level) && (af_level < depth);
   endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Simple dual-port register array: synchronous write port and a registered
// read port whose output resets to zero (the storage itself is never reset).
module fifo_param_ram
   import fifo_param_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int AW    = clog2(FIFO_DEPTH_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, registered flags and flush.
// Optional sticky OVF/UDF error outputs when FIFO_PARAM_ERR_EN is defined.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int WIDTH    = FIFO_WIDTH_DEF,
   parameter int DEPTH    = FIFO_DEPTH_DEF,
   parameter int AE_LEVEL = 4,
   parameter int AF_LEVEL = 12,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic             CLR,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             WE,
   input  logic             RE,
   output logic [WIDTH-1:0] DOUT,
   output logic             EF,
   output logic             PEF,
   output logic             FF,
   output logic             PFF,
   output logic [AW:0]      COUNT
`ifdef FIFO_PARAM_ERR_EN
   ,
   output logic             OVF,
   output logic             UDF
`endif
);

   if (!fifo_cfg_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_cfg_err
      $error("fifo_param: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
   end

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

   logic [AW:0] wadd, radd;
   logic [AW:0] wadd_nxt, radd_nxt, cnt_nxt;
   logic        wr_ok, rd_ok;
   logic        ram_we, ram_re;

   always_comb begin
      wr_ok    = WE && !FF;
      rd_ok    = RE && !EF;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      wadd_nxt = wadd;
      radd_nxt = radd;
      if (CLR) begin
         wadd_nxt = '0;
         radd_nxt = '0;
      end else begin
         ram_we = wr_ok;
         ram_re = rd_ok;
         if (wr_ok) wadd_nxt = wadd + PTR_ONE;
         if (rd_ok) radd_nxt = radd + PTR_ONE;
      end
      cnt_nxt = wadd_nxt - radd_nxt;
   end

   // Flags are registered from the post-edge occupancy so they line up with COUNT.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         wadd <= '0;
         radd <= '0;
         EF   <= 1'b1;
         PEF  <= 1'b1;
         FF   <= 1'b0;
         PFF  <= 1'b0;
      end else begin
         wadd <= wadd_nxt;
         radd <= radd_nxt;
         EF   <= (cnt_nxt == '0);
         PEF  <= (cnt_nxt <= AE_C);
         FF   <= (cnt_nxt == DEPTH_C);
         PFF  <= (cnt_nxt >= AF_C);
      end
   end

   assign COUNT = wadd - radd;

`ifdef FIFO_PARAM_ERR_EN
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         OVF <= 1'b0;
         UDF <= 1'b0;
      end else if (CLR) begin
         OVF <= 1'b0;
         UDF <= 1'b0;
      end else begin
         if (WE && FF) OVF <= 1'b1;
         if (RE && EF) UDF <= 1'b1;
      end
   end
`endif

   fifo_param_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (RESET_N),
      .we    (ram_we),
      .waddr (wadd[AW-1:0]),
      .wdata (DATA_IN),
      .re    (ram_re),
      .raddr (radd[AW-1:0]),
      .rdata (DOUT)
   );

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a default 8x16 instance and a 32x64 instance
// share one stimulus stream; queue-based models predict DOUT, COUNT and flags.
module tb_fifo_param;

   typedef struct {
      logic [31:0] dout;
      int          count;
      logic [3:0]  flags;  // {EF, PEF, FF, PFF}
      logic [1:0]  err;    // {OVF, UDF}
   } exp_t;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic        CLR;
   logic        WE;
   logic        RE;
   logic [31:0] DATA_IN;

   logic [7:0]  dout_s;
   logic [4:0]  count_s;
   logic        ef_s, pef_s, ff_s, pff_s;
   logic [31:0] dout_b;
   logic [6:0]  count_b;
   logic        ef_b, pef_b, ff_b, pff_b;
`ifdef FIFO_PARAM_ERR_EN
   logic        ovf_s, udf_s, ovf_b, udf_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mq_s[$];
   logic [31:0] mq_b[$];
   logic [31:0] m_dout_s, m_dout_b;
   bit          m_ovf_s, m_udf_s, m_ovf_b, m_udf_b;
   exp_t        q_exp_s[$];
   exp_t        q_exp_b[$];

   always #5 clk = ~clk;

   fifo_param u_small (
      .clk     (clk),
      .RESET_N (RESET_N),
      .CLR     (CLR),
      .DATA_IN (DATA_IN[7:0]),
      .WE      (WE),
      .RE      (RE),
      .DOUT    (dout_s),
      .EF      (ef_s),
      .PEF     (pef_s),
      .FF      (ff_s),
      .PFF     (pff_s),
      .COUNT   (count_s)
`ifdef FIFO_PARAM_ERR_EN
      ,
      .OVF     (ovf_s),
      .UDF     (udf_s)
`endif
   );

   fifo_param #(
      .WIDTH    (32),
      .DEPTH    (64),
      .AE_LEVEL (8),
      .AF_LEVEL (56)
   ) u_big (
      .clk     (clk),
      .RESET_N (RESET_N),
      .CLR     (CLR),
      .DATA_IN (DATA_IN),
      .WE      (WE),
      .RE      (RE),
      .DOUT    (dout_b),
      .EF      (ef_b),
      .PEF     (pef_b),
      .FF      (ff_b),
      .PFF     (pff_b),
      .COUNT   (count_b)
`ifdef FIFO_PARAM_ERR_EN
      ,
      .OVF     (ovf_b),
      .UDF     (udf_b)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int n, input int depth, input int ae, input int af,
                               input logic [31:0] dout, input bit ovf, input bit udf);
      exp_t e;
      e.dout  = dout;
      e.count = n;
      e.flags = {n == 0, n <= ae, n == depth, n >= af};
      e.err   = {ovf, udf};
      return e;
   endfunction

   task automatic model_reset();
      mq_s.delete();
      mq_b.delete();
      m_dout_s = '0;
      m_dout_b = '0;
      m_ovf_s  = 0; m_udf_s = 0;
      m_ovf_b  = 0; m_udf_b = 0;
      q_exp_s.delete();
      q_exp_b.delete();
   endtask

   task automatic model_edge(input bit we, input bit re, input bit clr, input logic [31:0] d);
      int ns, nb;
      ns = mq_s.size();
      nb = mq_b.size();
      if (clr) begin
         mq_s.delete(); mq_b.delete();
         m_ovf_s = 0; m_udf_s = 0; m_ovf_b = 0; m_udf_b = 0;
      end else begin
         if (we && ns == 16) m_ovf_s = 1;
         if (re && ns == 0)  m_udf_s = 1;
         if (re && ns > 0)   m_dout_s = mq_s.pop_front();
         if (we && ns < 16)  mq_s.push_back(d & 32'hff);
         if (we && nb == 64) m_ovf_b = 1;
         if (re && nb == 0)  m_udf_b = 1;
         if (re && nb > 0)   m_dout_b = mq_b.pop_front();
         if (we && nb < 64)  mq_b.push_back(d);
      end
      q_exp_s.push_back(mk(mq_s.size(), 16, 4, 12, m_dout_s, m_ovf_s, m_udf_s));
      q_exp_b.push_back(mk(mq_b.size(), 64, 8, 56, m_dout_b, m_ovf_b, m_udf_b));
   endtask

   task automatic step(input bit we, input bit re, input bit clr, input logic [31:0] d);
      @(negedge clk);
      WE = we; RE = re; CLR = clr; DATA_IN = d;
      @(posedge clk);
      model_edge(we, re, clr, d);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_cnt"},   32'(count_s), 0);
      check({tag, "_s_flags"}, {28'b0, ef_s, pef_s, ff_s, pff_s}, 32'b1100);
      check({tag, "_s_dout"},  32'(dout_s), 0);
      check({tag, "_b_cnt"},   32'(count_b), 0);
      check({tag, "_b_flags"}, {28'b0, ef_b, pef_b, ff_b, pff_b}, 32'b1100);
      check({tag, "_b_dout"},  dout_b, 0);
`ifdef FIFO_PARAM_ERR_EN
      check({tag, "_err"}, {28'b0, ovf_s, udf_s, ovf_b, udf_b}, 0);
`endif
   endtask

   // Monitor: one expected record per clock edge, compared half a cycle later.
   always @(negedge clk) begin
      exp_t e;
      if (q_exp_s.size() > 0) begin
         e = q_exp_s.pop_front();
         check("s_dout",  32'(dout_s), e.dout);
         check("s_count", 32'(count_s), 32'(e.count));
         check("s_flags", {28'b0, ef_s, pef_s, ff_s, pff_s}, {28'b0, e.flags});
`ifdef FIFO_PARAM_ERR_EN
         check("s_err", {30'b0, ovf_s, udf_s}, {30'b0, e.err});
`endif
      end
      if (q_exp_b.size() > 0) begin
         e = q_exp_b.pop_front();
         check("b_dout",  dout_b, e.dout);
         check("b_count", 32'(count_b), 32'(e.count));
         check("b_flags", {28'b0, ef_b, pef_b, ff_b, pff_b}, {28'b0, e.flags});
`ifdef FIFO_PARAM_ERR_EN
         check("b_err", {30'b0, ovf_b, udf_b}, {30'b0, e.err});
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pw, pr;
      RESET_N = 1'b0; CLR = 1'b0; WE = 1'b0; RE = 1'b0; DATA_IN = '0;
      model_reset();
      #12;
      check_reset_values("por");
      @(negedge clk);
      RESET_N = 1'b1;

      repeat (2) step(0, 0, 0, 0);
      for (int i = 1; i <= 17; i++) step(1, 0, 0, 32'(i));          // fill + overflow
      for (int i = 0; i < 17; i++)  step(0, 1, 0, 0);               // drain + underflow
      for (int i = 0; i < 8; i++)   step(1, 0, 0, 32'(100 + i));
      for (int i = 0; i < 40; i++)  step(1, 1, 0, 32'(200 + i));    // steady state, wrap
      for (int i = 0; i < 8; i++)   step(1, 0, 0, 32'(300 + i));    // small reaches full
      step(1, 1, 0, 32'h55);
      for (int i = 0; i < 15; i++)  step(0, 1, 0, 0);
      for (int i = 0; i < 8; i++)   step(0, 1, 0, 0);
      step(1, 1, 0, 32'hA5);                                         // simultaneous at empty
      step(0, 1, 0, 0);
      for (int i = 0; i < 10; i++)  step(1, 0, 0, 32'(400 + i));
      step(1, 0, 1, 32'hEE);                                         // flush beats write
      step(0, 1, 0, 0);

      for (int i = 0; i < 4; i++)   step(1, 0, 0, 32'(500 + i));
      #2;
      RESET_N = 1'b0;
      WE = 1'b0; RE = 1'b0; CLR = 1'b0;
      #1;
      check_reset_values("midrst");
      model_reset();
      @(negedge clk);
      RESET_N = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         pw = ((i / 500) % 2 == 0) ? 75 : 30;
         pr = ((i / 500) % 2 == 0) ? 30 : 75;
         step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
              $urandom_range(0, 199) == 0, $urandom);
      end

      step(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("sb_drained", 32'(q_exp_s.size() + q_exp_b.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
